// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx serialiser between
// NUM_REQ byte producers. Only one byte is in flight at a time. The
// start/ready handshake with uart_tx runs as IDLE -> START -> WAIT_LOW ->
// WAIT_HIGH.
// Optional feature: define UART_ARB_PACKET_LOCK_EN to add req_last. A
// granted requester then keeps the serialiser until its last byte is acked.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int ID_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
`ifdef UART_ARB_PACKET_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_last,
`endif
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic [DATA_BITS-1:0]          tx_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT_LOW, WAIT_HIGH} state_t;
  state_t state;

  // Unpack the flat data bus into one byte per requester.
  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
  end

  // Requesters allowed to compete in this arbitration cycle.
  logic [NUM_REQ-1:0] eligible;

`ifdef UART_ARB_PACKET_LOCK_EN
  logic locked;
  // While a packet is open, only the owner of the lock may be granted.
  always_comb begin
    eligible = req_valid;
    if (locked) eligible = req_valid & (NUM_REQ'(1) << grant_id);
  end
`else
  assign eligible = req_valid;
`endif

  // Round-robin search starting just after the last grant. The wrap is
  // modulo NUM_REQ, so indices at or above NUM_REQ are never produced.
  // A one-bit-wider candidate holds grant_id + k without overflow.
  logic                found;
  logic [ID_W-1:0]     winner;
  logic [ID_W:0]       cand;
  always_comb begin
    found  = 1'b0;
    winner = grant_id;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, grant_id} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && eligible[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  // Handshake FSM. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      req_ack  <= '0;
      grant_id <= ID_W'(NUM_REQ - 1);
      busy     <= 1'b0;
`ifdef UART_ARB_PACKET_LOCK_EN
      locked   <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      req_ack  <= '0;
      case (state)
        IDLE: begin
          if (tx_ready && found) begin
            tx_data  <= req_bytes[winner];
            grant_id <= winner;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tx_start          <= 1'b1;
          req_ack[grant_id] <= 1'b1;
`ifdef UART_ARB_PACKET_LOCK_EN
          locked            <= !req_last[grant_id];
`endif
          state             <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!tx_ready) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (tx_ready) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
